// File: rtl/r_type_issue_pkg.sv
// Shared R-type decode constants and issue-FSM encodings, used by the issue
// stage and the ALU control unit.
package r_type_issue_pkg;

  localparam int         INSTR_W      = 32;
  localparam logic [5:0] OPCODE_RTYPE = 6'h00;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_HELD  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } r_fields_t;

  // Only the six ALU R-type operations with a zero shift amount are issued.
  function automatic logic is_legal_rtype(input logic [INSTR_W-1:0] word);
    r_fields_t f;
    logic      funct_ok;
    f = word;
    case (f.funct)
      FUNCT_ADD, FUNCT_SUB, FUNCT_AND,
      FUNCT_OR,  FUNCT_NOR, FUNCT_SLT: funct_ok = 1'b1;
      default:                         funct_ok = 1'b0;
    endcase
    return (f.opcode == OPCODE_RTYPE) && (f.shamt == 5'd0) && funct_ok;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Power-of-two instruction buffer; pointers carry one extra bit so that
// full and empty are distinguishable without a separate counter.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/r_type_issue.sv
// R-type issue stage: buffers instruction words, decodes the head word and
// issues register fields one per cycle unless the datapath holds.
module r_type_issue
  import r_type_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  output logic               instr_ready,
  input  logic               hold,
  output logic               issue_valid,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [5:0]         funct,
  output logic               illegal,
  output logic [15:0]        issued_count,
  output logic [7:0]         illegal_count,
  output issue_state_e       state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;

  issue_state_e    state_q;
  issue_state_e    state_d;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [31:0]     head;
  r_fields_t       head_f;
  logic            head_legal;

  // Handshake: a word transfers on a rising edge where instr_valid && instr_ready;
  // instr_ready is purely "buffer not full" and never looks at instr_valid or hold.
  assign instr_ready = !full;
  assign push        = instr_valid && instr_ready;
  assign head_f      = head;
  assign head_legal  = is_legal_rtype(head);
  assign state_dbg   = state_q;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (instr),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Pops happen only in RUN with hold low; a simultaneous push keeps RUN alive.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (hold) begin
          state_d = ST_HELD;
        end else if (!empty) begin
          pop = 1'b1;
          if ((count == CW'(1)) && !push) state_d = ST_EMPTY;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HELD: begin
        if (!hold) state_d = empty ? ST_EMPTY : ST_RUN;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid   <= 1'b0;
      illegal       <= 1'b0;
      rs            <= '0;
      rt            <= '0;
      rd            <= '0;
      funct         <= '0;
      issued_count  <= '0;
      illegal_count <= '0;
    end else begin
      issue_valid <= 1'b0;
      illegal     <= 1'b0;
      if (pop) begin
        if (head_legal) begin
          issue_valid  <= 1'b1;
          rs           <= head_f.rs;
          rt           <= head_f.rt;
          rd           <= head_f.rd;
          funct        <= head_f.funct;
          issued_count <= issued_count + 16'd1;
        end else begin
          illegal <= 1'b1;
          if (illegal_count != 8'hFF) illegal_count <= illegal_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_r_type_issue.sv
// Self-checking bench for r_type_issue: vector table plus directed sequences
// for hold/backpressure, streaming, mid-operation reset and counter limits.
`timescale 1ns/1ps
module tb_r_type_issue;
  import r_type_issue_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         instr_valid = 1'b0;
  logic [31:0]  instr = '0;
  logic         hold = 1'b0;
  logic         instr_ready;
  logic         issue_valid;
  logic [4:0]   rs, rt, rd;
  logic [5:0]   funct;
  logic         illegal;
  logic [15:0]  issued_count;
  logic [7:0]   illegal_count;
  issue_state_e state_dbg;

  r_type_issue #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .hold          (hold),
    .issue_valid   (issue_valid),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .funct         (funct),
    .illegal       (illegal),
    .issued_count  (issued_count),
    .illegal_count (illegal_count),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                     input logic [4:0] d, input logic [4:0] sh, input logic [5:0] f);
    return {op, s, t, d, sh, f};
  endfunction

  // ---------------- scoreboard ----------------
  logic [20:0] exp_q[$];
  logic        sb_en = 1'b0;
  logic [20:0] sb_e;
  int          sb_issues = 0;
  int          sb_first = -1;
  int          sb_last = -1;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sb_en && issue_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_issue", 32'(1), 32'(0));
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_issue_fields", 32'({rs, rt, rd, funct}), 32'(sb_e));
      end
      if (sb_first < 0) sb_first = cyc;
      sb_last = cyc;
      sb_issues++;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] w;
    logic        legal;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  f;
  } vec_t;

  vec_t        vecs[11];
  logic [15:0] exp_issued  = '0;
  logic [7:0]  exp_illegal = '0;
  logic [4:0]  last_rs = '0, last_rt = '0, last_rd = '0;
  logic [5:0]  last_f = '0;

  // Streams n identical words with hold low; no per-word scoreboard.
  task automatic stream_fast(input int n, input logic legal);
    int sent;
    int budget;
    sent   = 0;
    budget = n + 20;
    instr_valid = 1'b1;
    instr = legal ? 32'h00221820 : 32'h8C220004;
    while (sent < n && budget > 0) begin
      if (instr_ready) sent++;
      if (sent == n) instr_valid = 1'b1;
      @(negedge clk);
      if (sent == n) instr_valid = 1'b0;
      budget--;
    end
    instr_valid = 1'b0;
    if (sent != n) chk("stream_accepts", 32'(sent), 32'(n));
    repeat (4) @(negedge clk);
  endtask

  int idx;
  int first_c;
  int last_c;
  int sent;
  int ready_drop;
  int bad_issue;
  logic ready_seen;
  logic [31:0] w;

  initial begin
    vecs[0]  = '{32'h00221820,               1'b1, 5'd1,  5'd2,  5'd3,  6'h20};
    vecs[1]  = '{32'h8C220004,               1'b0, 5'd0,  5'd0,  5'd0,  6'h00};
    vecs[2]  = '{32'h00862822,               1'b1, 5'd4,  5'd6,  5'd5,  6'h22};
    vecs[3]  = '{mk(6'h0, 8, 9, 7, 0, 6'h24),  1'b1, 5'd8,  5'd9,  5'd7,  6'h24};
    vecs[4]  = '{mk(6'h0, 31, 30, 29, 0, 6'h25), 1'b1, 5'd31, 5'd30, 5'd29, 6'h25};
    vecs[5]  = '{mk(6'h0, 1, 1, 0, 0, 6'h27),  1'b1, 5'd1,  5'd1,  5'd0,  6'h27};
    vecs[6]  = '{mk(6'h0, 10, 11, 12, 0, 6'h2A), 1'b1, 5'd10, 5'd11, 5'd12, 6'h2A};
    vecs[7]  = '{mk(6'h0, 1, 2, 3, 5, 6'h20),  1'b0, 5'd0,  5'd0,  5'd0,  6'h00};
    vecs[8]  = '{mk(6'h0, 1, 2, 3, 0, 6'h21),  1'b0, 5'd0,  5'd0,  5'd0,  6'h00};
    vecs[9]  = '{mk(6'h0, 1, 2, 3, 0, 6'h00),  1'b0, 5'd0,  5'd0,  5'd0,  6'h00};
    vecs[10] = '{32'h04221820,               1'b0, 5'd0,  5'd0,  5'd0,  6'h00};

    // reset values while rst_n is low
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'(1));
    chk("rst_issue_valid", 32'(issue_valid), 32'(0));
    chk("rst_illegal", 32'(illegal), 32'(0));
    chk("rst_fields", 32'({rs, rt, rd, funct}), 32'(0));
    chk("rst_issued_count", 32'(issued_count), 32'(0));
    chk("rst_illegal_count", 32'(illegal_count), 32'(0));
    chk("rst_state", 32'(state_dbg), 32'(ST_EMPTY));

    // release and push on the very first edge after release
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      instr_valid = 1'b1;
      instr = vecs[i].w;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      if (vecs[i].legal) begin
        exp_issued++;
        last_rs = vecs[i].rs; last_rt = vecs[i].rt; last_rd = vecs[i].rd; last_f = vecs[i].f;
      end else if (exp_illegal != 8'hFF) begin
        exp_illegal++;
      end
      chk($sformatf("vec%0d_issue_valid", i), 32'(issue_valid), 32'(vecs[i].legal));
      chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(!vecs[i].legal));
      chk($sformatf("vec%0d_rs", i), 32'(rs), 32'(last_rs));
      chk($sformatf("vec%0d_rt", i), 32'(rt), 32'(last_rt));
      chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(last_rd));
      chk($sformatf("vec%0d_funct", i), 32'(funct), 32'(last_f));
      chk($sformatf("vec%0d_issued_count", i), 32'(issued_count), 32'(exp_issued));
      chk($sformatf("vec%0d_illegal_count", i), 32'(illegal_count), 32'(exp_illegal));
      @(negedge clk);
      chk($sformatf("vec%0d_valid_pulse_end", i), 32'(issue_valid), 32'(0));
      chk($sformatf("vec%0d_illegal_pulse_end", i), 32'(illegal), 32'(0));
    end

    // hold high: fill to DEPTH, fifth word refused, then drain in order
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr_valid = 1'b1;
      instr = mk(6'h0, 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'd0, FUNCT_ADD);
      chk($sformatf("hold_ready_%0d", i), 32'(instr_ready), 32'(i < 4));
      @(negedge clk);
      chk($sformatf("hold_no_issue_%0d", i), 32'(issue_valid), 32'(0));
    end
    instr_valid = 1'b0;
    chk("hold_state", 32'(state_dbg), 32'(ST_HELD));
    chk("hold_still_full", 32'(instr_ready), 32'(0));
    chk("hold_fields_retained", 32'(rs), 32'(last_rs));
    hold = 1'b0;
    idx = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (issue_valid) begin
        if (idx < 4) begin
          chk($sformatf("drain%0d_rs", idx), 32'(rs), 32'(idx + 1));
          chk($sformatf("drain%0d_rt", idx), 32'(rt), 32'(idx + 2));
          chk($sformatf("drain%0d_rd", idx), 32'(rd), 32'(idx + 3));
        end else begin
          chk("drain_extra_issue", 32'(1), 32'(0));
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        idx++;
      end
    end
    chk("drain_count", 32'(idx), 32'(4));
    chk("drain_consecutive", 32'(last_c - first_c), 32'(3));
    exp_issued = exp_issued + 16'd4;
    chk("drain_issued_count", 32'(issued_count), 32'(exp_issued));

    // continuous streaming with scoreboard
    sb_en = 1'b1; sb_issues = 0; sb_first = -1; sb_last = -1;
    sent = 0; ready_drop = 0;
    instr_valid = 1'b1;
    for (int c = 0; c < 40 && sent < 20; c++) begin
      w = mk(6'h0, 5'(sent), 5'(31 - sent), 5'((sent * 3) % 32), 5'd0, (sent % 2) ? FUNCT_SLT : FUNCT_SUB);
      instr = w;
      ready_seen = instr_ready;
      if (!ready_seen) ready_drop++;
      else exp_q.push_back({5'(sent), 5'(31 - sent), 5'((sent * 3) % 32), (sent % 2) ? FUNCT_SLT : FUNCT_SUB});
      @(negedge clk);
      if (ready_seen) sent++;
    end
    instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    sb_en = 1'b0;
    chk("stream_sent", 32'(sent), 32'(20));
    chk("stream_issues", 32'(sb_issues), 32'(20));
    chk("stream_queue_empty", 32'(exp_q.size()), 32'(0));
    chk("stream_ready_stable", 32'(ready_drop), 32'(0));
    chk("stream_one_per_cycle", 32'(sb_last - sb_first), 32'(19));
    exp_issued = exp_issued + 16'd20;
    chk("stream_issued_count", 32'(issued_count), 32'(exp_issued));

    // reset with three words buffered
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1;
      instr = mk(6'h0, 5'd5, 5'd6, 5'd7, 5'd0, FUNCT_ADD);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_issue_valid", 32'(issue_valid), 32'(0));
    chk("midrst_illegal", 32'(illegal), 32'(0));
    chk("midrst_fields", 32'({rs, rt, rd, funct}), 32'(0));
    chk("midrst_ready", 32'(instr_ready), 32'(1));
    chk("midrst_counts", 32'({issued_count, illegal_count}), 32'(0));
    chk("midrst_state", 32'(state_dbg), 32'(ST_EMPTY));
    @(negedge clk);
    hold = 1'b0;
    rst_n = 1'b1;
    bad_issue = 0;
    repeat (6) begin
      @(negedge clk);
      if (issue_valid || illegal) bad_issue++;
    end
    chk("midrst_no_issue_after", 32'(bad_issue), 32'(0));
    chk("midrst_issued_count", 32'(issued_count), 32'(0));

    // counter wrap and saturation
    stream_fast(65535, 1'b1);
    chk("wrap_ffff", 32'(issued_count), 32'(16'hFFFF));
    stream_fast(1, 1'b1);
    chk("wrap_to_zero", 32'(issued_count), 32'(0));
    stream_fast(255, 1'b0);
    chk("illegal_reach_ff", 32'(illegal_count), 32'(8'hFF));
    stream_fast(1, 1'b0);
    chk("illegal_saturate", 32'(illegal_count), 32'(8'hFF));
    chk("wrap_issued_unchanged", 32'(issued_count), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/r_type_issue.md
R_TYPE_ISSUE -- requirements
Module: r_type_issue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction buffer depth in entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 instr_valid  input  1  upstream presents an instruction word.
REQ-005 instr  input  32  MIPS instruction word.
REQ-006 instr_ready  output  1  buffer can accept a word this cycle.
REQ-007 hold  input  1  downstream datapath stall request.
REQ-008 issue_valid  output  1  fields on rs/rt/rd/funct are valid this cycle; acts as the datapath write-back strobe.
REQ-009 rs, rt, rd  output  5 each  decoded register specifiers.
REQ-010 funct  output  6  decoded function code.
REQ-011 illegal  output  1  one-cycle pulse per discarded word.
REQ-012 issued_count  output  16  count of issued instructions.
REQ-013 illegal_count  output  8  count of discarded words.

Function
REQ-014 A word SHALL be accepted on a rising edge where instr_valid and instr_ready are both high; instr_ready SHALL equal "buffer not full" and SHALL NOT depend on instr_valid or hold.
REQ-015 The buffer SHALL be FIFO ordered; pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with one extra bit to distinguish full from empty.
REQ-016 A head word SHALL be legal only if opcode [31:26]=0, shamt [10:6]=0, and funct [5:0] is one of 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
REQ-017 The FSM SHALL have states EMPTY (buffer empty), RUN (head available, hold low), and HELD (hold high); EMPTY->RUN on first accept; RUN->HELD on hold high; HELD->RUN on hold low with a non-empty buffer; RUN/HELD->EMPTY when the last entry is popped.
REQ-018 In RUN, each cycle SHALL pop exactly one head word: if legal, drive rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0] as registered outputs with issue_valid=1 in the following cycle; if illegal, issue_valid=0 and illegal=1 in the following cycle.
REQ-019 Latency SHALL be one cycle: a word accepted at edge N into an empty buffer with hold low SHALL appear with issue_valid high after edge N+1.
REQ-020 While hold is high, no pop SHALL occur, issue_valid SHALL be 0, rs/rt/rd/funct SHALL retain their last values, and accepts SHALL continue until full.
REQ-021 A simultaneous accept and pop SHALL leave occupancy unchanged; an accept into a full buffer SHALL NOT occur.
REQ-022 With buffer empty, issue_valid and illegal SHALL be 0 and field outputs SHALL retain their last values.
REQ-023 rd=0 instructions SHALL be issued normally.
REQ-024 issued_count SHALL increment per issue and wrap from 0xFFFF to 0; illegal_count SHALL increment per discard and saturate at 0xFF.

Reset
REQ-025 While rst_n is low: buffer empty, state EMPTY, instr_ready=1, issue_valid=0, illegal=0, rs=rt=rd=0, funct=0, both counters 0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered words; none SHALL issue after release.
REQ-027 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-028 Opcode value, the six legal funct constants, and FSM state encodings SHALL reside in a shared package used by this block and the ALU control unit.
REQ-029 The buffer SHALL be a sub-module named instr_fifo (parameterised by DEPTH and width); decode, FSM and counters SHALL reside in r_type_issue.

Verification
REQ-030 Push 0x00221820 (add $3,$1,$2), hold low -> next cycle issue_valid=1, rs=1, rt=2, rd=3, funct=0x20; issued_count=1.
REQ-031 Push 0x8C220004 (lw) then 0x00862822 (sub) -> illegal pulse one cycle, illegal_count=1; then issue rs=4, rt=6, rd=5, funct=0x22.
REQ-032 hold high, push 5 words with DEPTH=4 -> instr_ready low after 4th accept, 5th word not accepted, issue_valid stays 0; release hold -> 4 issues on consecutive cycles in push order.
REQ-033 Continuous push with hold low for 20 cycles -> one issue per cycle, occupancy stable, no word lost or duplicated.
REQ-034 Assert rst_n low with 3 words buffered -> all outputs at reset values immediately, no issue after release; issued_count=0.
REQ-035 Preload issued_count path with 65536 legal issues -> issued_count wraps to 0; 256 illegal words -> illegal_count holds 0xFF.
